// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg
//   Shared types and widths for the FIFO write-side arbiter.
//   arb_state_t : arbiter FSM state (IDLE, BURST)
//   BEAT_W      : width of the in-burst word counter
//   CNT_W       : width of each optional per-requester word counter
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int BEAT_W = 8;
  localparam int CNT_W  = 16;

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// rr_pick
//   Combinational round-robin picker: returns the first set bit of req
//   searching upward from last+1 with wraparound.
// Ports:
//   req   : request vector, bit i = requester i
//   last  : index of the previously served requester
//   gnt   : one-hot pick (all zero when req is zero)
//   found : high when any request is set
module rr_pick #(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last,
  output logic [NREQ-1:0]  gnt,
  output logic             found
);

  always_comb begin
    logic [IDX_W-1:0] idx;
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    // k = NREQ wraps back to last itself, so it has the lowest priority
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDX_W'((int'(last) + k) % NREQ);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb
//   Round-robin arbiter sharing the write port of the async FIFO between
//   NREQ producers in the wclk domain. One requester is granted at a time
//   for at most MAX_BURST words; wfull stalls the burst without dropping data.
// Ports:
//   wclk, wrst_n : write clock, async active-low reset
//   req/req_data : per-requester word-valid and data (slice i*DATASIZE)
//   req_ack      : one-hot pulse, word of requester i accepted this cycle
//   wfull        : FIFO full flag (registered in wclk domain)
//   winc/wdata   : FIFO write strobe and data (wdata is 0 when winc is 0)
//   gnt          : one-hot current grant, zero when idle
//   busy         : high while a burst is in progress
//   word_cnt     : per-requester saturating accepted-word counts, only
//                  present when FIFO_WR_ARB_STATS_EN is defined
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no grant; pick next requester round-robin from last+1
// BURST | gnt holds one requester; words flow while req[g] & ~wfull
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int DATASIZE  = 8,
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 8
) (
  input  logic                     wclk,
  input  logic                     wrst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DATASIZE-1:0] req_data,
  output logic [NREQ-1:0]          req_ack,
  input  logic                     wfull,
  output logic                     winc,
  output logic [DATASIZE-1:0]      wdata,
  output logic [NREQ-1:0]          gnt,
`ifdef FIFO_WR_ARB_STATS_EN
  output logic [NREQ*CNT_W-1:0]    word_cnt,
`endif
  output logic                     busy
);

  localparam int                IDX_W     = $clog2(NREQ);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0]  LAST_RST  = IDX_W'(NREQ - 1);

  arb_state_t          state;
  logic [IDX_W-1:0]    last;
  logic [IDX_W-1:0]    gidx;
  logic [IDX_W-1:0]    pick_idx;
  logic [BEAT_W-1:0]   beat;
  logic [NREQ-1:0]     pick;
  logic                found;
  logic                req_g;
  logic                xfer;
  logic [DATASIZE-1:0] data_g;

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (req),
    .last  (last),
    .gnt   (pick),
    .found (found)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NREQ; i++)
      if (pick[i]) pick_idx = IDX_W'(i);
  end

  always_comb begin
    data_g = '0;
    for (int i = 0; i < NREQ; i++)
      if (gnt[i]) data_g = req_data[i*DATASIZE +: DATASIZE];
  end

  // wfull gates the strobe in the same cycle, so no write is issued while full
  assign busy    = (state == BURST);
  assign req_g   = |(req & gnt);
  assign xfer    = busy & req_g & ~wfull;
  assign winc    = xfer;
  assign wdata   = xfer ? data_g : '0;
  assign req_ack = xfer ? gnt : '0;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state <= IDLE;
      gnt   <= '0;
      gidx  <= '0;
      last  <= LAST_RST;
      beat  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state <= BURST;
            gnt   <= pick;
            gidx  <= pick_idx;
            beat  <= '0;
          end
        end
        BURST: begin
          // a stalled requester keeps the grant; only its own req drop or
          // the last beat ends the burst
          if (!req_g || (xfer && beat == LAST_BEAT)) begin
            state <= IDLE;
            gnt   <= '0;
            last  <= gidx;
          end else if (xfer) begin
            beat <= beat + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  logic [CNT_W-1:0] cnt [NREQ];

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      for (int i = 0; i < NREQ; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++)
        if (req_ack[i] && (cnt[i] != '1)) cnt[i] <= cnt[i] + 1'b1;
    end
  end

  always_comb begin
    word_cnt = '0;
    for (int i = 0; i < NREQ; i++) word_cnt[i*CNT_W +: CNT_W] = cnt[i];
  end
`endif

endmodule
